// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states and bit-timing helpers.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Clock cycles per bit on the wire.
    function automatic int unsigned symbol_edge_time(input int unsigned clock_freq,
                                                     input int unsigned baud_rate);
        return clock_freq / baud_rate;
    endfunction

    // Clock cycles from the start edge to the middle of the start bit.
    function automatic int unsigned sample_time(input int unsigned clock_freq,
                                                input int unsigned baud_rate);
        return symbol_edge_time(clock_freq, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/uart_receiver_midsample_if.sv
// Output handshake bundle of the UART receiver (byte, valid/ready, error pulses).
interface uart_receiver_midsample_if;

    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       frame_error;
    logic       overrun;

    modport master (
        output data_out,
        output data_out_valid,
        output frame_error,
        output overrun,
        input  data_out_ready
    );

    modport slave (
        input  data_out,
        input  data_out_valid,
        input  frame_error,
        input  overrun,
        output data_out_ready
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, with a configurable reset value.
module sync_2ff #(
    parameter int unsigned      WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Metastability filter: two back-to-back flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_receiver_midsample.sv
// UART 8N1 receiver: samples mid-bit, 1-deep output register with valid/ready,
// one-cycle frame_error and overrun pulses. Never stalls the serial line.
module uart_receiver_midsample
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 125_000_000,
    parameter int unsigned BAUD_RATE  = 115_200
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        serial_in,
    uart_receiver_midsample_if.master   rx
);

    localparam int unsigned SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned SAMPLE_TIME      = sample_time(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned CNT_W            = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;

    logic             w_sync;
    logic             r_prev;
    uart_state_t      r_state;
    uart_state_t      w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [2:0]       r_bit_idx;
    logic [2:0]       w_bit_idx_next;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_next;
    logic             w_load;
    logic             w_stop_bad;

    logic [7:0]       r_data_out;
    logic             r_valid;
    logic             r_frame_error;
    logic             r_overrun;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (serial_in),
        .o_q   (w_sync)
    );

    // Receive FSM state, bit timer, bit index, shift register and edge-detect history.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_prev    <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_prev    <= w_sync;
        end
    end

    // Next-state logic: start-bit validation, mid-bit data sampling, stop-bit check.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt + CNT_W'(1);
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_load         = 1'b0;
        w_stop_bad     = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                if (r_prev && !w_sync) begin
                    w_state_next = START;
                end
            end
            START: begin
                if (r_cnt == CNT_W'(SAMPLE_TIME - 1)) begin
                    w_cnt_next     = '0;
                    w_bit_idx_next = '0;
                    w_state_next   = w_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_cnt == CNT_W'(SYMBOL_EDGE_TIME - 1)) begin
                    w_cnt_next   = '0;
                    w_shift_next = {w_sync, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                // Leave at mid-stop-bit so a back-to-back start edge is not missed.
                if (r_cnt == CNT_W'(SYMBOL_EDGE_TIME - 1)) begin
                    w_cnt_next   = '0;
                    w_state_next = IDLE;
                    w_load       = w_sync;
                    w_stop_bad   = !w_sync;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Output holding register: a newly received byte always wins over the held one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_out    <= 8'h00;
            r_valid       <= 1'b0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_frame_error <= w_stop_bad;
            r_overrun     <= w_load && r_valid && !rx.data_out_ready;
            if (w_load) begin
                r_data_out <= r_shift;
                r_valid    <= 1'b1;
            end else if (r_valid && rx.data_out_ready) begin
                r_valid    <= 1'b0;
            end
        end
    end

    assign rx.data_out       = r_data_out;
    assign rx.data_out_valid = r_valid;
    assign rx.frame_error    = r_frame_error;
    assign rx.overrun        = r_overrun;

endmodule

// File: doc/uart_receiver_midsample.md
UART_RECEIVER_MIDSAMPLE -- requirements
Module: uart_receiver_midsample

Interface
REQ-001 Parameter CLOCK_FREQ, default 125_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115_200, serial bit rate in bits/s.
REQ-003 Port clk  input  1  system clock; all logic on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port serial_in  input  1  asynchronous UART line; idles high.
REQ-006 Port data_out  output  8  received byte, LSB first on the wire.
REQ-007 Port data_out_valid  output  1  byte held on data_out is valid.
REQ-008 Port data_out_ready  input  1  consumer accepts the byte when high together with valid.
REQ-009 Port frame_error  output  1  one-cycle pulse when the stop bit samples low.
REQ-010 Port overrun  output  1  one-cycle pulse when a new byte completes while valid is still held.

Function
REQ-011 The block SHALL define SYMBOL_EDGE_TIME = CLOCK_FREQ/BAUD_RATE and SAMPLE_TIME = SYMBOL_EDGE_TIME/2, with counter width $clog2(SYMBOL_EDGE_TIME).
REQ-012 serial_in SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value, adding 2 cycles of latency.
REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-014 IDLE->START on a synchronized falling edge; the clock counter clears.
REQ-015 In START at count SAMPLE_TIME-1: line low -> DATA, with the counter cleared; line high -> IDLE (glitch reject, no flags).
REQ-016 DATA SHALL sample at each SYMBOL_EDGE_TIME-1 count, shift into bit 7 (right shift), and advance to STOP after 8 samples.
REQ-017 STOP SHALL sample at SYMBOL_EDGE_TIME-1. High -> load data_out and set valid. Low -> pulse frame_error and discard the byte. Either way the FSM returns to IDLE.
REQ-018 Return to IDLE occurs at mid-stop-bit, so a back-to-back start edge is detected with no lost frame.
REQ-019 data_out_valid SHALL stay high until a cycle with data_out_ready=1; data_out SHALL be stable while valid.
REQ-020 If a good stop bit is sampled while valid=1 and ready=0, data_out SHALL be overwritten, valid SHALL stay 1, and overrun SHALL pulse.
REQ-021 If ready=1 in the same cycle a new byte loads, the new byte wins and valid remains 1.
REQ-022 Receive SHALL proceed regardless of the output handshake; the receiver never stalls the line.

Reset
REQ-023 Reset SHALL force state IDLE, counters 0, data_out 8'h00, data_out_valid 0, frame_error 0, overrun 0, and synchronizer flops 1.
REQ-024 Reset mid-frame SHALL abandon the frame; the next falling edge after reset starts a fresh frame.

Structure
REQ-025 A shared uart_pkg SHALL hold the FSM state enum and the SYMBOL_EDGE_TIME/SAMPLE_TIME calculation functions, shared with the transmitter.
REQ-026 The synchronizer SHALL be a separate sub-module, sync_2ff (parameterised width, reset value 1).

Verification
REQ-027 The bench SHALL loop the existing transmitter to this receiver at default parameters: send 8'hA5 -> data_out=8'hA5 with valid high about 9.5 bit times after the start edge.
REQ-028 The bench SHALL drive a 0.25-bit-time low glitch on an idle line -> no valid, no frame_error, FSM back in IDLE.
REQ-029 The bench SHALL send 8'h3C with the stop bit forced low -> frame_error pulses one cycle, valid stays 0.
REQ-030 The bench SHALL hold ready=0 and send 8'h11 then 8'h22 back-to-back -> overrun pulses once, data_out=8'h22, valid=1.
REQ-031 The bench SHALL assert reset during bit 4 of 8'hFF and then send 8'h00 -> only 8'h00 is received.
REQ-032 The bench SHALL send 8'h55 then 8'hAA with zero idle and ready=1 -> both bytes are received in order with no errors.
